// File: rtl/regbank_wb_arbiter.sv
// Writeback arbiter and clear sequencer that owns the Reg_Bank write port.
// Two requesters (ALU = req0, LSU = req1) share one registered write port;
// a clear sequence can overwrite x1..x31 with CLR_VALUE, one per cycle.
module regbank_wb_arbiter #(
  parameter int                 DATA_W     = 32,
  parameter int                 ADDR_W     = 5,
  parameter int                 STARVE_MAX = 4,
  parameter logic [DATA_W-1:0]  CLR_VALUE  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3
);

  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                gnt0, gnt1;

  // Next-state, grant and write-port selection for the current state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    starve_d = starve_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    a_d      = a_q;
    wd_d     = wd_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    clr_busy = 1'b0;
    clr_done = 1'b0;

    unique case (state_q)
      ST_ARB: begin
        if (clr_start) begin
          // Starting a clear pre-empts any grant this cycle.
          state_d = ST_CLEAR;
        end else if (req0_valid && (!req1_valid || starve_q == STARVE_LIM)) begin
          gnt0 = 1'b1;
        end else if (req1_valid) begin
          gnt1 = 1'b1;
        end

        if (gnt0) begin
          we_d = (req0_addr != '0);
          a_d  = req0_addr;
          wd_d = req0_data;
        end else if (gnt1) begin
          we_d = (req1_addr != '0);
          a_d  = req1_addr;
          wd_d = req1_data;
        end
      end

      ST_CLEAR: begin
        clr_busy = 1'b1;
        we_d     = 1'b1;
        a_d      = idx_q;
        wd_d     = CLR_VALUE;
        if (idx_q == IDX_LAST) begin
          idx_d   = IDX_FIRST;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_FIRST;
        end
      end

      ST_DONE: begin
        clr_done = 1'b1;
        state_d  = ST_ARB;
      end

      default: state_d = ST_ARB;
    endcase

    // A valid req0 that loses the cycle (for any reason) ages toward priority.
    if (!req0_valid || gnt0) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Readies are gated by reset so nothing is accepted while rst is high.
  assign req0_ready = gnt0 & ~rst;
  assign req1_ready = gnt1 & ~rst;

  assign WE3 = we_q;
  assign A3  = a_q;
  assign WD3 = wd_q;

  // State, counters and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ARB;
      starve_q <= '0;
      idx_q    <= IDX_FIRST;
      we_q     <= 1'b0;
      a_q      <= '0;
      wd_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      starve_q <= starve_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      a_q      <= a_d;
      wd_q     <= wd_d;
    end
  end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Scoreboard bench: the driver predicts grants and writes from the arbitration
// rules and queues expected writes; a monitor pops them as WE3 appears.
module tb_regbank_wb_arbiter;

  localparam int          STARVE_MAX = 4;
  localparam logic [31:0] CLR_VALUE  = 32'h0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        clr_start, clr_busy, clr_done;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  regbank_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard and reference state.
  wr_t         exp_q[$];
  logic [31:0] exp_rf[32];
  logic [31:0] rb[32];          // Reg_Bank stand-in fed by the DUT write port
  logic [31:0] snap[32];
  int          starve  = 0;     // consecutive denied cycles of a valid req0
  int          clr_cnt = 0;     // 0 idle, 1..31 index being cleared, 32 done cycle

  // Pending requests: held stable until the model says they were accepted.
  logic        p0v = 0, p1v = 0;
  logic [4:0]  p0a = 0, p1a = 0;
  logic [31:0] p0d = 0, p1d = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reg_Bank stand-in: x0 is hardwired to zero.
  always @(posedge clk) begin
    if (WE3 && A3 != 5'd0) rb[A3] <= WD3;
  end

  // Monitor: every write the DUT presents must be the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && WE3) begin
        if (exp_q.size() == 0) begin
          check("spurious_we3", {63'd0, WE3}, 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", {59'd0, A3}, {59'd0, e.a});
          check("wr_data", {32'd0, WD3}, {32'd0, e.d});
        end
      end
    end
  end

  // One clock cycle: drive pending requests, predict and check the response.
  task automatic cycle(input logic start);
    logic g0, g1, eb, ed, v0;
    @(negedge clk);
    req0_valid = p0v; req0_addr = p0a; req0_data = p0d;
    req1_valid = p1v; req1_addr = p1a; req1_data = p1d;
    clr_start  = start;
    #1;
    g0 = 0; g1 = 0;
    v0 = p0v;
    eb = (clr_cnt >= 1 && clr_cnt <= 31);
    ed = (clr_cnt == 32);
    if (clr_cnt == 0 && !start) begin
      if (p0v && (!p1v || starve == STARVE_MAX)) g0 = 1;
      else if (p1v) g1 = 1;
    end
    check("req0_ready", {63'd0, req0_ready}, {63'd0, g0});
    check("req1_ready", {63'd0, req1_ready}, {63'd0, g1});
    check("one_grant", {63'd0, req0_ready & req1_ready}, 64'd0);
    check("clr_busy", {63'd0, clr_busy}, {63'd0, eb});
    check("clr_done", {63'd0, clr_done}, {63'd0, ed});
    if (g0) begin
      if (p0a != 0) begin exp_q.push_back('{a: p0a, d: p0d}); exp_rf[p0a] = p0d; end
      p0v = 0;
    end
    if (g1) begin
      if (p1a != 0) begin exp_q.push_back('{a: p1a, d: p1d}); exp_rf[p1a] = p1d; end
      p1v = 0;
    end
    starve = (v0 && !g0) ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
    if (eb) begin
      exp_q.push_back('{a: 5'(clr_cnt), d: CLR_VALUE});
      exp_rf[clr_cnt] = CLR_VALUE;
      clr_cnt++;
    end else if (ed) begin
      clr_cnt = 0;
    end else if (start) begin
      clr_cnt = 1;
    end
  endtask

  // Let outstanding writes reach the Reg_Bank stand-in, then compare x1..x31.
  task automatic check_rf(input string name);
    cycle(0); cycle(0);
    for (int i = 1; i < 32; i++) check(name, {32'd0, rb[i]}, {32'd0, exp_rf[i]});
  endtask

  task automatic req0(input logic [4:0] a, input logic [31:0] d);
    p0v = 1; p0a = a; p0d = d;
  endtask

  task automatic req1(input logic [4:0] a, input logic [31:0] d);
    p1v = 1; p1a = a; p1d = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin rb[i] = 0; exp_rf[i] = 0; end
    rst = 1; clr_start = 0;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    #2;
    // Reset state: readies low even with requests present.
    req0_valid = 1; req1_valid = 1;
    #1;
    check("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
    check("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
    check("rst_we3", {63'd0, WE3}, 64'd0);
    check("rst_a3", {59'd0, A3}, 64'd0);
    check("rst_wd3", {32'd0, WD3}, 64'd0);
    check("rst_busy", {63'd0, clr_busy}, 64'd0);
    check("rst_done", {63'd0, clr_done}, 64'd0);
    req0_valid = 0; req1_valid = 0;
    #17 rst = 0;   // released at t=20

    // T1: single LSU write.
    req1(5'd5, 32'h1234ABCD);
    cycle(0);
    check_rf("t1_rf");

    // T2: both valid for six cycles; ALU request re-issued when accepted.
    req0(5'd3, 32'h0000_0003);
    for (int c = 0; c < 6; c++) begin
      if (!p0v) req0(5'd3, 32'h3000_0000 + 32'(c));
      req1(5'd7, 32'h7000_0000 + 32'(c));
      cycle(0);
    end
    while (p0v || p1v) cycle(0);

    // T3: x0 write is accepted and dropped.
    req0(5'd0, 32'hDEADBEEF);
    cycle(0);
    check_rf("t3_rf");

    // T4: preload, then clear.
    req1(5'd1, 32'h0000AAAA);
    cycle(0);
    req0(5'd31, 32'h00005555);
    cycle(0);
    cycle(1);
    for (int c = 0; c < 34; c++) cycle(c == 5);   // mid-clear start is ignored
    check_rf("t4_rf");

    // T5: clear start collides with an LSU request.
    req1(5'd9, 32'h0909_0909);
    cycle(1);
    for (int c = 0; c < 36; c++) cycle(0);
    check_rf("t5_rf");

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      if (!p0v && ($urandom_range(0, 2) != 0)) req0(5'($urandom_range(0, 31)), $urandom);
      if (!p1v && ($urandom_range(0, 2) != 0)) req1(5'($urandom_range(0, 31)), $urandom);
      cycle(0);
    end
    for (int c = 0; c < 10 && (p0v || p1v); c++) cycle(0);
    check("drain", {62'd0, p0v, p1v}, 64'd0);
    // Make sure the registers hold non-clear values before the aborted clear.
    for (int i = 1; i < 32; i++) begin
      req0(5'(i), 32'hC000_0000 + 32'(i));
      cycle(0);
    end
    check_rf("pre_t6_rf");

    // T6: asynchronous reset while A3=10 is being written.
    for (int i = 0; i < 32; i++) snap[i] = exp_rf[i];
    cycle(1);
    for (int c = 0; c < 10; c++) cycle(0);
    @(negedge clk);
    #2;
    check("t6_a3_before", {59'd0, A3}, 64'd10);
    rst = 1;
    #1;
    check("t6_we3_drop", {63'd0, WE3}, 64'd0);
    check("t6_busy_drop", {63'd0, clr_busy}, 64'd0);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    for (int i = 10; i < 32; i++) exp_rf[i] = snap[i];
    clr_cnt = 0; starve = 0; p0v = 0; p1v = 0;
    #13 rst = 0;
    for (int c = 0; c < 5; c++) cycle(0);   // no clr_done, plain ARB
    check_rf("t6_rf");
    req1(5'd12, 32'h1212_1212);
    cycle(0);
    check_rf("t6_post_rf");

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
